// File: rtl/mips_isa_pkg.sv
// Shared MIPS subset definitions: opcode/function codes and fetch FSM encoding.
// Used by the fetch/issue stage and by the main control decoder.
package mips_isa_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  // Fetch/issue state encoding
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } fetch_state_e;

  // Field extraction helpers
  function automatic logic [5:0] instr_opcode(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] instr);
    return instr[5:0];
  endfunction

  // True for jr: register-indirect jump resolved in the fetch stage
  function automatic logic is_jr(input logic [31:0] instr);
    return (instr[31:26] == OP_RTYPE) && (instr[5:0] == FN_JR);
  endfunction

  // True for j: pseudo-direct jump resolved in the fetch stage
  function automatic logic is_j(input logic [31:0] instr);
    return instr[31:26] == OP_J;
  endfunction

endpackage

// File: rtl/isa_legal_check.sv
// Combinational membership test for the supported MIPS subset.
// Shared with the main control decoder so both agree on what is legal.
module isa_legal_check
  import mips_isa_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       legal
);

  // Opcode first; R-type additionally qualified by the function field
  always_comb begin
    legal = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        unique case (funct)
          FN_ADD, FN_SUB, FN_SUBU, FN_AND,
          FN_OR, FN_NOR, FN_SLT, FN_JR: legal = 1'b1;
          default:                      legal = 1'b0;
        endcase
      end
      OP_J, OP_ADDI, OP_SLTI, OP_ANDI,
      OP_ORI, OP_LW, OP_SW:             legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_fetch_issue.sv
// Instruction fetch and issue stage: owns the PC, fetches one word at a time over
// a req/ack handshake, splits it into MIPS fields and issues it under valid/ready.
// j and jr are resolved here by redirecting the PC at issue time.
module instr_fetch_issue
  import mips_isa_pkg::*;
#(
  parameter int unsigned         IMEM_AW  = 32,
  parameter logic [IMEM_AW-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  // Instruction memory
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  // Issue interface
  output logic               issue_valid,
  input  logic               issue_ready,
  output logic [5:0]         Opcode,
  output logic [5:0]         Function,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [15:0]        imm,
  input  logic [31:0]        rs_data,
  output logic [IMEM_AW-1:0] pc_out,
  output logic               illegal,
  output logic [31:0]        instr_count
);

  fetch_state_e       state;
  logic [IMEM_AW-1:0] pc;
  logic [31:0]        instr;
  logic [31:0]        count;
  logic               req_q;
  logic               valid_q;

  logic [IMEM_AW-1:0] pc_plus4;
  logic [31:0]        pc_plus4_w;
  logic [31:0]        jump_target;
  logic [IMEM_AW-1:0] pc_next;
  logic               legal;
  logic               handshake;

  isa_legal_check u_legal (
    .opcode (instr_opcode(instr)),
    .funct  (instr_funct(instr)),
    .legal  (legal)
  );

  assign handshake = valid_q & issue_ready;

  // Next PC at issue: j keeps the top nibble of PC+4, jr takes rs_data verbatim
  // (misaligned targets pass through unchanged), everything else steps by 4.
  always_comb begin
    pc_plus4    = pc + IMEM_AW'(4);
    pc_plus4_w  = 32'(pc_plus4);
    jump_target = {pc_plus4_w[31:28], instr[25:0], 2'b00};
    pc_next     = pc_plus4;
    if (is_j(instr)) begin
      pc_next = IMEM_AW'(jump_target);
    end else if (is_jr(instr)) begin
      pc_next = IMEM_AW'(rs_data);
    end
  end

  // Fetch/issue FSM with registered req/valid; reset wins over any in-flight request
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= RESET_PC;
      instr   <= '0;
      count   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (run) begin
            state <= S_FETCH;
            req_q <= 1'b1;
          end
        end
        S_FETCH: begin
          // run is deliberately ignored here: an issued request always completes
          if (imem_ack) begin
            instr   <= imem_rdata;
            state   <= S_ISSUE;
            req_q   <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (handshake) begin
            count   <= count + 32'd1;
            pc      <= pc_next;
            valid_q <= 1'b0;
            if (run) begin
              state <= S_FETCH;
              req_q <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Fields are zeroed when nothing is issued so the decoder sees an idle opcode
  always_comb begin
    imem_req    = req_q;
    imem_addr   = pc;
    issue_valid = valid_q;
    instr_count = count;
    Opcode      = '0;
    Function    = '0;
    rs          = '0;
    rt          = '0;
    rd          = '0;
    imm         = '0;
    illegal     = 1'b0;
    pc_out      = '0;
    if (valid_q) begin
      Opcode   = instr[31:26];
      Function = instr[5:0];
      rs       = instr[25:21];
      rt       = instr[20:16];
      rd       = instr[15:11];
      imm      = instr[15:0];
      illegal  = ~legal;
      pc_out   = pc;
    end
  end

endmodule

// File: doc/instr_fetch_issue.md
Name: instr_fetch_issue

Overview:
- Upstream producer of the opcode/function fields consumed by the main control decoder.
- Holds the PC and fetches 32-bit words from instruction memory over a req/ack handshake.
- Splits each word into MIPS fields and presents them under a valid/ready handshake.
- Resolves j and jr locally by redirecting the PC; flags words outside the supported subset.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_AW, 32, instruction memory byte-address width.

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  fetch enable; 0 = do not start new fetches
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  IMEM_AW  byte address = PC, stable while imem_req=1
- imem_ack  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  32  instruction word
- issue_valid  out  1  decoded fields valid
- issue_ready  in  1  consumer accepts the current instruction
- Opcode  out  6  instr[31:26]
- Function  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- imm  out  16  instr[15:0]
- rs_data  in  32  register-file read of rs, used as jr target
- pc_out  out  IMEM_AW  PC of the issued instruction
- illegal  out  1  issued word not in supported set (qualified by issue_valid)
- instr_count  out  32  count of accepted instructions

Behaviour:
- States: S_IDLE, S_FETCH, S_ISSUE.
- Reset (synchronous): state=S_IDLE, PC=RESET_PC, instruction register=0, instr_count=0. All outputs 0 except imem_addr=RESET_PC. Reset overrides every other event, including an in-flight request; imem_req is low the cycle after reset is sampled.
- S_IDLE: imem_req=0. Go to S_FETCH when run=1.
- S_FETCH:
  - imem_req=1, imem_addr=PC.
  - Ack may arrive the same cycle req rises (combinational memory) or any later cycle.
  - On imem_ack: latch imem_rdata into the instruction register, go to S_ISSUE.
  - imem_ack while not in S_FETCH is ignored.
  - run dropping mid-request does not abort the request.
- S_ISSUE:
  - issue_valid=1; fields and illegal driven from the instruction register, stable until handshake.
  - On issue_valid & issue_ready:
    - instr_count += 1; wraps 32'hFFFF_FFFF -> 0.
    - j (Opcode=0x02): PC <= {PC+4[31:28], instr[25:0], 2'b00}.
    - jr (Opcode=0x00, Function=0x08): PC <= rs_data sampled this cycle.
    - Otherwise PC <= PC+4, wrapping mod 2^IMEM_AW.
    - Next state: S_FETCH if run=1, else S_IDLE.
- When issue_valid=0, Opcode, Function, rs, rt, rd, imm and illegal are forced to 0. Opcode=0/Function=0 matches no supported instruction, so the decoder idles.
- Latency:
  - ack to issue_valid is 1 cycle.
  - Handshake to next imem_req is 1 cycle.
  - Best-case throughput is 1 instruction per 2 cycles.
- Supported set:
  - R-type (Opcode=0x00) with Function 0x20, 0x22, 0x23, 0x24, 0x25, 0x27, 0x2A, 0x08.
  - Opcodes 0x02, 0x08, 0x0A, 0x0C, 0x0D, 0x23, 0x2B.
  - Anything else: illegal=1. An illegal word still issues normally and the PC advances by 4.
- Misaligned redirect (jr target[1:0]!=0): PC loads the value unchanged; alignment is not checked here.

Decomposition:
- Shared package mips_isa_pkg:
  - Opcode constants: OP_RTYPE=0x00, OP_J=0x02, OP_ADDI=0x08, OP_SLTI=0x0A, OP_ANDI=0x0C, OP_ORI=0x0D, OP_LW=0x23, OP_SW=0x2B.
  - Function constants: FN_JR=0x08, FN_ADD=0x20, FN_SUB=0x22, FN_SUBU=0x23, FN_AND=0x24, FN_OR=0x25, FN_NOR=0x27, FN_SLT=0x2A.
  - Fetch state encoding.
- The main control decoder also uses this package.
- One sub-module, isa_legal_check: combinational opcode/function to legal bit, reusable by the decoder.

Test Plan:
- Reset then run=1, memory acks with 1-cycle delay returning 0x012A4020 (add): imem_addr=0x0, then issue_valid with Opcode=0x00, Function=0x20, rs=9, rt=10, rd=8; after ready, next imem_addr=0x4.
- Word 0x08000010 (j) at PC=0x4, ready=1: next imem_addr=0x40; instr_count=2.
- Word 0x03E00008 (jr $31) with rs_data=0x0000_0100: rs=31; next imem_addr=0x100.
- issue_ready held 0 for 5 cycles: fields and issue_valid stable, no imem_req, instr_count unchanged.
- Word 0xFC000000: illegal=1 while issue_valid=1; PC advances by 4.
- reset asserted while imem_req=1 and ack pending: next cycle imem_req=0, issue_valid=0, imem_addr=RESET_PC, instr_count=0; a late ack is ignored.
